// File: rtl/task_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : task_dispatcher_pkg
// Purpose  : Shared task-memory geometry, end-marker value, pointer widths,
//            dispatcher FSM encoding and the end-marker helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package task_dispatcher_pkg;

  localparam int INSN_SIZE      = 16;
  localparam int INSN_COUNT     = 16;
  localparam int TASK_MEM_DEPTH = 8;
  localparam int TASK_MEM_WIDTH = INSN_COUNT * INSN_SIZE;
  localparam int INSN_RANGE     = INSN_SIZE;
  localparam int TM_RANGE       = TASK_MEM_DEPTH * TASK_MEM_WIDTH;

  localparam logic [3:0] END_NIBBLE = 4'hF;

  localparam int SLOT_PTR_W = $clog2(INSN_COUNT);
  localparam int TASK_PTR_W = $clog2(TASK_MEM_DEPTH);
  localparam int COUNT_W    = $clog2(TASK_MEM_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // True when the word's top nibble marks the final instruction of a task.
  function automatic logic is_end_marker(input logic [INSN_RANGE-1:0] word);
    return word[INSN_SIZE-1 -: 4] == END_NIBBLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/task_dispatcher_slot_mux.sv
`default_nettype none
// ============================================================================
// Module   : task_slot_mux
// Purpose  : Combinational select of word [task_ptr][slot_ptr] from the flat
//            task bus, plus an all-zero flag for the whole selected task.
// Ports    : task_memory_i - flat task bus
//            task_ptr_i    - task index
//            slot_ptr_i    - slot index within the task
//            word_o        - selected instruction word
//            task_zero_o   - selected task contains only zero words
// Revision : 1.0 - initial release
// ============================================================================
module task_slot_mux
  import task_dispatcher_pkg::*;
(
  input  logic [TM_RANGE-1:0]   task_memory_i,
  input  logic [TASK_PTR_W-1:0] task_ptr_i,
  input  logic [SLOT_PTR_W-1:0] slot_ptr_i,
  output logic [INSN_RANGE-1:0] word_o,
  output logic                  task_zero_o
);

  logic [TASK_MEM_WIDTH-1:0] w_task_words;

  always_comb begin
    w_task_words = task_memory_i[int'(task_ptr_i) * TASK_MEM_WIDTH +: TASK_MEM_WIDTH];
    word_o       = w_task_words[int'(slot_ptr_i) * INSN_SIZE +: INSN_SIZE];
    task_zero_o  = (w_task_words == '0);
  end

endmodule
`default_nettype wire

// File: rtl/task_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : task_dispatcher
// Purpose  : Walks the flat task bus after a start request and streams each
//            task's instructions over a valid/ready handshake.
// Ports    : clk, reset          - clock, async active-high reset
//            task_memory        - flat task bus (stable while busy)
//            start              - one-cycle run request (honoured in IDLE only)
//            insn_ready         - downstream accepts current word
//            insn_valid/data/addr/task_id/insn_last - registered word stream
//            busy, done         - run in progress / end-of-run pulse
//            task_count         - tasks fully streamed in the last run
// Revision : 1.0 - initial release
// ============================================================================
module task_dispatcher
  import task_dispatcher_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TM_RANGE-1:0]   task_memory,
  input  logic                  start,
  input  logic                  insn_ready,
  output logic                  insn_valid,
  output logic [INSN_RANGE-1:0] insn_data,
  output logic [SLOT_PTR_W-1:0] insn_addr,
  output logic [TASK_PTR_W-1:0] task_id,
  output logic                  insn_last,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_W-1:0]    task_count
);

  state_e                  state_q, state_d;
  logic [TASK_PTR_W-1:0]   task_ptr_q, task_ptr_d;
  logic [SLOT_PTR_W-1:0]   slot_ptr_q, slot_ptr_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic                    valid_q, valid_d;
  logic [INSN_RANGE-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [SLOT_PTR_W-1:0]   w_slot_sel;
  logic [INSN_RANGE-1:0]   w_word;
  logic                    w_task_zero;
  logic                    w_last;

  // The output register is loaded one cycle ahead: in CHECK with slot 0,
  // in STREAM with the slot following the one currently presented.
  assign w_slot_sel = (state_q == ST_STREAM) ? slot_ptr_q + 1'b1 : '0;

  task_slot_mux u_slot_mux (
    .task_memory_i (task_memory),
    .task_ptr_i    (task_ptr_q),
    .slot_ptr_i    (w_slot_sel),
    .word_o        (w_word),
    .task_zero_o   (w_task_zero)
  );

  assign w_last = is_end_marker(w_word) ||
                  (w_slot_sel == SLOT_PTR_W'(INSN_COUNT - 1));

  always_comb begin
    state_d    = state_q;
    task_ptr_d = task_ptr_q;
    slot_ptr_d = slot_ptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          task_ptr_d = '0;
          slot_ptr_d = '0;
          count_d    = '0;
          busy_d     = 1'b1;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_task_zero) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          slot_ptr_d = '0;
          valid_d    = 1'b1;
          data_d     = w_word;
          last_d     = w_last;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (valid_q && insn_ready) begin
          if (!last_q) begin
            slot_ptr_d = w_slot_sel;
            data_d     = w_word;
            last_d     = w_last;
          end else begin
            count_d    = count_q + 1'b1;
            slot_ptr_d = '0;
            valid_d    = 1'b0;
            last_d     = 1'b0;
            if (task_ptr_q == TASK_PTR_W'(TASK_MEM_DEPTH - 1)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              task_ptr_d = task_ptr_q + 1'b1;
              state_d    = ST_CHECK;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      task_ptr_q <= '0;
      slot_ptr_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      task_ptr_q <= task_ptr_d;
      slot_ptr_q <= slot_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign insn_valid = valid_q;
  assign insn_data  = data_q;
  assign insn_addr  = slot_ptr_q;
  assign task_id    = task_ptr_q;
  assign insn_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign task_count = count_q;

endmodule
`default_nettype wire
